fadd_issue_arbiter: RTL and testbench
=====================================

# fadd_issue_arbiter

- Shares one combinational single-precision adder datapath (`float_adder_32` style: A, B -> out, NaN_flag, overflow_flag) among NUM_REQ vector-ALU requesters.
- Round-robin arbitration, a two-stage registered issue/retire pipeline with full backpressure, tagged responses and exception/throughput statistics counters.
- Sits between the VALU lane issue ports and the shared adder instance.

## Interface

Parameters:
- NUM_REQ, 4 — number of requesters (≥2).
- TAG_W, 4 — width of per-operation tag returned with result.
- ID_W, 2 — width of requester index; must be ≥ clog2(NUM_REQ).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operation valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  32*NUM_REQ  operand A, requester i in bits [32i+31:32i].
- req_b  in  32*NUM_REQ  operand B, same packing.
- req_tag  in  TAG_W*NUM_REQ  tag, same packing.
- fadd_a  out  32  registered operand A to adder.
- fadd_b  out  32  registered operand B to adder.
- fadd_out  in  32  adder result (combinational from fadd_a/fadd_b).
- fadd_nan  in  1  adder NaN flag.
- fadd_ovf  in  1  adder overflow flag.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accept.
- rsp_id  out  ID_W  requester index of result.
- rsp_tag  out  TAG_W  tag of result.
- rsp_data  out  32  result.
- rsp_nan  out  1  captured NaN flag.
- rsp_ovf  out  1  captured overflow flag.
- stat_ops  out  32  completed-result count, wraps.
- stat_exc  out  16  count of results with nan|ovf, saturates at 16'hFFFF.

## Operation

- State: S1 (issue register: s1_valid, operands, id, tag), S2 (response register: s2_valid, data, flags, id, tag), ptr (round-robin pointer, ID_W bits).
- s2_load = s1_valid && (!s2_valid || rsp_ready).
- s1_free = !s1_valid || s2_load.
- Arbitration (combinational): grant goes to the first i with req_valid[i], scanning ptr, ptr+1, … mod NUM_REQ.
  - req_ready[i] = s1_free && grant[i] && !rst.
- Handshake occurs when req_valid[i] && req_ready[i].
  - On handshake: S1 loads req_a/req_b/req_tag slice i and id=i; ptr <= (i+1) mod NUM_REQ.
  - With no handshake, ptr holds.
- fadd_a/fadd_b are the S1 operand registers.
- On s2_load: S2 captures fadd_out, fadd_nan, fadd_ovf, S1 id/tag.
- s1_valid next = handshake ? 1 : (s2_load ? 0 : s1_valid).
- s2_valid next = s2_load ? 1 : ((rsp_valid && rsp_ready) ? 0 : s2_valid).
- Response output: rsp_valid = s2_valid; rsp_* are driven from S2.
  - S2 contents are stable while rsp_valid && !rsp_ready.
- Statistics update on each rsp_valid && rsp_ready:
  - stat_ops += 1, wrapping at 2^32.
  - stat_exc += 1 if rsp_nan|rsp_ovf, saturating.
- Requesters must hold valid and data until ready; req_valid must not depend on req_ready.
- Results return in acceptance order.
- No operation is dropped or duplicated except on reset.

## Timing

- Reset values: s1_valid=0, s2_valid=0, ptr=0, fadd_a=0, fadd_b=0, rsp_data=0, rsp_id=0, rsp_tag=0, rsp_nan=0, rsp_ovf=0, stat_ops=0, stat_exc=0. req_ready=0 while rst high.
- Latency: handshake at edge N gives rsp_valid=1 after edge N+1, with rsp_ready held high.
- Throughput: one op/cycle sustained when rsp_ready=1.
- Backpressure with rsp_ready=0: at most two ops buffered (S2, S1); req_ready=0 thereafter.
  - When rsp_ready rises, S2 drains, S1 advances and a new handshake occurs in the same cycle.
- Simultaneous S2 drain and S2 reload in one cycle: s2_valid stays 1 and S2 holds new contents.
- Reset mid-operation: all in-flight ops are discarded immediately (asynchronous); the first grant after release goes to requester 0 if valid.
- ptr wrap: grant to NUM_REQ-1 sets ptr=0.

## Test plan

- Single op: requester 2 sends A=32'h3F800000, B=32'h40000000, tag=5, rsp_ready=1.
  - Required: rsp_valid after exactly 2 edges, rsp_id=2, rsp_tag=5, rsp_data = fadd_out for those operands (32'h40400000 with bench adder model), stat_ops=1.
- Full contention: all 4 req_valid held high for 8 cycles.
  - Required: grants in order 0,1,2,3,0,1,2,3, one per cycle; responses in the same order.
- Backpressure: all requesters valid, rsp_ready=0 for 5 cycles.
  - Required: exactly 2 handshakes, then req_ready=0; rsp_data stable. After release, the sequence continues with no loss or duplication.
- Exceptions: A=32'h7F800000, B=32'hFF800000 with adder NaN flag asserted.
  - Required: rsp_nan=1, stat_exc increments by 1; 65540 such results leave stat_exc=16'hFFFF.
- Sparse round robin: only requesters 1 and 3 valid, ptr=2.
  - Required: grant 3 first, then 1, 3, 1 alternating.
- Reset mid-flight: assert rst with s1_valid=s2_valid=1.
  - Required: rsp_valid=0, req_ready=0, and stat counters 0 in the same cycle. After release, no stale response appears; the first grant goes to requester 0.

Source files
------------

// File: rtl/fadd_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fadd_issue_arbiter
// Description : Round-robin issue arbiter sharing one combinational FP32
//               adder among NUM_REQ requesters, with a two-stage registered
//               issue/retire pipeline, tagged responses and statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module fadd_issue_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [32*NUM_REQ-1:0]    req_a,
    input  logic [32*NUM_REQ-1:0]    req_b,
    input  logic [TAG_W*NUM_REQ-1:0] req_tag,
    output logic [31:0]              fadd_a,
    output logic [31:0]              fadd_b,
    input  logic [31:0]              fadd_out,
    input  logic                     fadd_nan,
    input  logic                     fadd_ovf,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [31:0]              rsp_data,
    output logic                     rsp_nan,
    output logic                     rsp_ovf,
    output logic [31:0]              stat_ops,
    output logic [15:0]              stat_exc
);

    localparam logic [15:0] C_EXC_MAX = 16'hFFFF;

    logic              r_s1_valid;
    logic [31:0]       r_s1_a;
    logic [31:0]       r_s1_b;
    logic [ID_W-1:0]   r_s1_id;
    logic [TAG_W-1:0]  r_s1_tag;
    logic              r_s2_valid;
    logic [31:0]       r_s2_data;
    logic              r_s2_nan;
    logic              r_s2_ovf;
    logic [ID_W-1:0]   r_s2_id;
    logic [TAG_W-1:0]  r_s2_tag;
    logic [ID_W-1:0]   r_ptr;
    logic [31:0]       r_stat_ops;
    logic [15:0]       r_stat_exc;

    logic              w_s2_load;
    logic              w_s1_free;
    logic              w_rsp_fire;
    logic              w_hs;
    logic              w_any;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]   w_gnt_id;
    logic [ID_W-1:0]   w_ptr_next;
    logic [31:0]       w_sel_a;
    logic [31:0]       w_sel_b;
    logic [TAG_W-1:0]  w_sel_tag;

    assign w_s2_load  = r_s1_valid && (!r_s2_valid || rsp_ready);
    assign w_s1_free  = !r_s1_valid || w_s2_load;
    assign w_rsp_fire = r_s2_valid && rsp_ready;

    // First valid requester scanning from ptr upward, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx       = 0;
        w_any     = 1'b0;
        w_grant   = '0;
        w_gnt_id  = '0;
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_tag = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_any && req_valid[idx]) begin
                w_any        = 1'b1;
                w_grant[idx] = 1'b1;
                w_gnt_id     = ID_W'(idx);
                w_sel_a      = req_a[idx*32 +: 32];
                w_sel_b      = req_b[idx*32 +: 32];
                w_sel_tag    = req_tag[idx*TAG_W +: TAG_W];
            end
        end
    end

    assign w_ptr_next = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + 1'b1;
    assign req_ready  = (w_s1_free && !rst) ? w_grant : '0;
    assign w_hs       = w_any && w_s1_free && !rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_id    <= '0;
            r_s1_tag   <= '0;
            r_ptr      <= '0;
        end else begin
            if (w_hs) begin
                r_s1_valid <= 1'b1;
                r_s1_a     <= w_sel_a;
                r_s1_b     <= w_sel_b;
                r_s1_id    <= w_gnt_id;
                r_s1_tag   <= w_sel_tag;
                r_ptr      <= w_ptr_next;
            end else if (w_s2_load) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    // S2 reload takes priority over drain so a same-cycle drain+reload keeps valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_data  <= '0;
            r_s2_nan   <= 1'b0;
            r_s2_ovf   <= 1'b0;
            r_s2_id    <= '0;
            r_s2_tag   <= '0;
        end else begin
            if (w_s2_load) begin
                r_s2_valid <= 1'b1;
                r_s2_data  <= fadd_out;
                r_s2_nan   <= fadd_nan;
                r_s2_ovf   <= fadd_ovf;
                r_s2_id    <= r_s1_id;
                r_s2_tag   <= r_s1_tag;
            end else if (w_rsp_fire) begin
                r_s2_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_ops <= '0;
            r_stat_exc <= '0;
        end else if (w_rsp_fire) begin
            r_stat_ops <= r_stat_ops + 32'd1;
            if ((r_s2_nan || r_s2_ovf) && (r_stat_exc != C_EXC_MAX)) begin
                r_stat_exc <= r_stat_exc + 16'd1;
            end
        end
    end

    assign fadd_a    = r_s1_a;
    assign fadd_b    = r_s1_b;
    assign rsp_valid = r_s2_valid;
    assign rsp_id    = r_s2_id;
    assign rsp_tag   = r_s2_tag;
    assign rsp_data  = r_s2_data;
    assign rsp_nan   = r_s2_nan;
    assign rsp_ovf   = r_s2_ovf;
    assign stat_ops  = r_stat_ops;
    assign stat_exc  = r_stat_exc;

endmodule
`default_nettype wire

// File: tb/tb_fadd_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fadd_issue_arbiter
// Description : Directed bench for fadd_issue_arbiter with a queue-based
//               reference model and a behavioural FP32 adder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fadd_issue_arbiter;

    localparam int N  = 4;
    localparam int TW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [TW*N-1:0] req_tag;
    logic [31:0]     fadd_a, fadd_b, fadd_out;
    logic            fadd_nan, fadd_ovf;
    logic            rsp_valid, rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [TW-1:0]   rsp_tag;
    logic [31:0]     rsp_data;
    logic            rsp_nan, rsp_ovf;
    logic [31:0]     stat_ops;
    logic [15:0]     stat_exc;

    always #5 clk = ~clk;

    fadd_issue_arbiter #(.NUM_REQ(N), .TAG_W(TW), .ID_W(IW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
        .fadd_a(fadd_a), .fadd_b(fadd_b), .fadd_out(fadd_out),
        .fadd_nan(fadd_nan), .fadd_ovf(fadd_ovf),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_tag(rsp_tag), .rsp_data(rsp_data),
        .rsp_nan(rsp_nan), .rsp_ovf(rsp_ovf),
        .stat_ops(stat_ops), .stat_exc(stat_exc)
    );

    // Behavioural single-precision adder (denormals flushed, truncating).
    function automatic real sp2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'h00)      d = {x[31], 63'd0};
        else if (x[30:23] == 8'hFF) d = {x[31], 11'h7FF, x[22:0], 29'd0};
        else                        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        int e;
        d = $realtobits(r);
        e = int'(d[62:52]);
        if (e == 2047) return {d[63], 8'hFF, d[51:29] | {22'd0, (d[51:0] != 52'd0)}};
        e = e - 896;
        if (e >= 255) return {d[63], 8'hFF, 23'd0};
        if (e <= 0)   return {d[63], 31'd0};
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fp_sum(input logic [31:0] a, input logic [31:0] b);
        return r2sp(sp2r(a) + sp2r(b));
    endfunction

    function automatic logic fp_nan(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = fp_sum(a, b);
        return (s[30:23] == 8'hFF) && (s[22:0] != 23'd0);
    endfunction

    function automatic logic fp_ovf(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s;
        s = fp_sum(a, b);
        return (s[30:0] == 31'h7F800000) && (a[30:23] != 8'hFF) && (b[30:23] != 8'hFF);
    endfunction

    assign fadd_out = fp_sum(fadd_a, fadd_b);
    assign fadd_nan = fp_nan(fadd_a, fadd_b);
    assign fadd_ovf = fp_ovf(fadd_a, fadd_b);

    int n_vec  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: in-order queue of accepted ops, each stamped with its accept edge.
    typedef struct {
        int          id;
        int          tag;
        logic [31:0] a;
        logic [31:0] b;
        int          cyc;
    } op_t;

    op_t         mq[$];
    int          m_ptr = 0;
    int          cyc = 0;
    logic [31:0] m_ops = '0;
    int          m_exc = 0;
    int          gnt_log[$];
    int          rsp_log[$];
    int          n_hs = 0;
    int          n_rsp = 0;

    function automatic int model_grant();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (req_valid[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic m_free();
        return !((mq.size() == 2) && !rsp_ready);
    endfunction

    function automatic logic head_vis();
        return (mq.size() > 0) && (cyc > mq[0].cyc + 1);
    endfunction

    task automatic model_clear();
        mq.delete();
        m_ptr = 0;
        m_ops = '0;
        m_exc = 0;
    endtask

    always @(posedge clk) begin
        if (rst) begin
            model_clear();
        end else begin
            logic fr, vis;
            int   g;
            op_t  o;
            fr  = m_free();
            vis = head_vis();
            g   = model_grant();
            if (vis && rsp_ready) begin
                o = mq.pop_front();
                m_ops = m_ops + 32'd1;
                if ((fp_nan(o.a, o.b) || fp_ovf(o.a, o.b)) && m_exc < 65535) m_exc++;
            end
            if (g >= 0 && fr) begin
                mq.push_back('{g, int'(req_tag[TW*g +: TW]), req_a[32*g +: 32], req_b[32*g +: 32], cyc});
                m_ptr = (g + 1) % N;
            end
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    gnt_log.push_back(i);
                    n_hs++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                rsp_log.push_back(int'(rsp_id));
                n_rsp++;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        logic [N-1:0] er;
        int           g;
        if (rst) begin
            model_clear();
            chk("rst_req_ready", req_ready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_stat_ops", stat_ops, 0);
            chk("rst_stat_exc", stat_exc, 0);
            chk("rst_fadd_a", fadd_a, 0);
            chk("rst_fadd_b", fadd_b, 0);
            chk("rst_rsp_fields", {rsp_data, rsp_id, rsp_tag, rsp_nan, rsp_ovf}, 0);
        end else begin
            er = '0;
            g  = model_grant();
            if (g >= 0 && m_free()) er[g] = 1'b1;
            chk("req_ready", req_ready, er);
            chk("rsp_valid", rsp_valid, head_vis());
            if (head_vis() && rsp_valid) begin
                chk("rsp_id", rsp_id, mq[0].id);
                chk("rsp_tag", rsp_tag, mq[0].tag);
                chk("rsp_data", rsp_data, fp_sum(mq[0].a, mq[0].b));
                chk("rsp_nan", rsp_nan, fp_nan(mq[0].a, mq[0].b));
                chk("rsp_ovf", rsp_ovf, fp_ovf(mq[0].a, mq[0].b));
            end
            chk("stat_ops", stat_ops, m_ops);
            chk("stat_exc", stat_exc, m_exc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input int tag);
        req_valid[i]         = v;
        req_a[32*i +: 32]    = a;
        req_b[32*i +: 32]    = b;
        req_tag[TW*i +: TW]  = TW'(tag);
    endtask

    task automatic set_all(input logic v);
        for (int i = 0; i < N; i++)
            set_req(i, v, 32'h40000000 | (32'(i) << 20), 32'h3F800000, i + 8);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_log(input string name, input int which, input int k, input int exp);
        int act;
        act = -1;
        if (which == 0 && k < gnt_log.size()) act = gnt_log[k];
        if (which == 1 && k < rsp_log.size()) act = rsp_log[k];
        chk(name, act, exp);
    endtask

    initial begin
        logic [31:0] held;
        int          hs0, rsp0;
        logic        done;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        rst = 1'b0;

        // Single op from requester 2
        rsp_ready = 1'b1;
        set_req(2, 1'b1, 32'h3F800000, 32'h40000000, 5);
        tick();
        set_req(2, 1'b0, 32'h0, 32'h0, 0);
        chk("single_valid_edge1", rsp_valid, 0);
        tick();
        chk("single_valid_edge2", rsp_valid, 1);
        chk("single_id", rsp_id, 2);
        chk("single_tag", rsp_tag, 5);
        chk("single_data", rsp_data, 32'h40400000);
        tick();
        chk("single_stat_ops", stat_ops, 1);

        // Full contention from ptr=0
        do_reset();
        gnt_log.delete();
        rsp_log.delete();
        set_all(1'b1);
        repeat (8) tick();
        set_all(1'b0);
        repeat (4) tick();
        chk("cont_ngrant", gnt_log.size(), 8);
        for (int k = 0; k < 8; k++) begin
            chk_log("cont_grant", 0, k, k % 4);
            chk_log("cont_rsp", 1, k, k % 4);
        end

        // Backpressure: two ops buffered, then drain with continuing traffic
        gnt_log.delete();
        rsp_log.delete();
        rsp_ready = 1'b0;
        hs0 = n_hs;
        set_all(1'b1);
        repeat (2) tick();
        held = rsp_data;
        repeat (3) tick();
        chk("bp_handshakes", n_hs - hs0, 2);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_data_stable", rsp_data, held);
        rsp_ready = 1'b1;
        repeat (4) tick();
        set_all(1'b0);
        repeat (4) tick();
        chk("bp_ngrant", gnt_log.size(), 6);
        chk("bp_nrsp", rsp_log.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk_log("bp_grant", 0, k, k % 4);
            chk_log("bp_rsp", 1, k, k % 4);
        end

        // Sparse round robin with ptr=2
        do_reset();
        set_req(1, 1'b1, 32'h3F800000, 32'h3F800000, 1);
        tick();
        set_req(1, 1'b0, 32'h0, 32'h0, 0);
        repeat (3) tick();
        gnt_log.delete();
        set_req(1, 1'b1, 32'h40800000, 32'h3F800000, 2);
        set_req(3, 1'b1, 32'h41000000, 32'h3F800000, 3);
        repeat (4) tick();
        set_all(1'b0);
        repeat (3) tick();
        chk("rr_ngrant", gnt_log.size(), 4);
        chk_log("rr_grant0", 0, 0, 3);
        chk_log("rr_grant1", 0, 1, 1);
        chk_log("rr_grant2", 0, 2, 3);
        chk_log("rr_grant3", 0, 3, 1);

        // Reset mid-flight with both stages full
        rsp_ready = 1'b0;
        set_all(1'b1);
        repeat (3) tick();
        chk("mid_full_rsp_valid", rsp_valid, 1);
        chk("mid_full_req_ready", req_ready, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_req_ready", req_ready, 0);
        chk("mid_stat_ops", stat_ops, 0);
        chk("mid_stat_exc", stat_exc, 0);
        tick();
        rst = 1'b0;
        rsp_ready = 1'b1;
        gnt_log.delete();
        tick();
        chk("mid_no_stale", rsp_valid, 0);
        chk_log("mid_first_grant", 0, 0, 0);
        set_all(1'b0);
        repeat (4) tick();

        // Exceptions and stat_exc saturation
        do_reset();
        hs0  = n_hs;
        rsp0 = n_rsp;
        set_req(0, 1'b1, 32'h7F800000, 32'hFF800000, 3);
        done = 1'b0;
        for (int t = 0; t < 10 && !done; t++) begin
            tick();
            if (rsp_valid) done = 1'b1;
        end
        chk("exc_rsp_seen", done, 1);
        chk("exc_rsp_nan", rsp_nan, 1);
        tick();
        chk("exc_first_count", stat_exc, 1);
        done = 1'b0;
        for (int t = 0; t < 70000 && !done; t++) begin
            if (n_hs - hs0 >= 65540) req_valid[0] = 1'b0;
            if (n_rsp - rsp0 >= 65540) done = 1'b1;
            else tick();
        end
        chk("exc_finished", done, 1);
        chk("exc_saturated", stat_exc, 16'hFFFF);
        chk("exc_ops", stat_ops, 65540);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
